// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet stream arbiter.
package eth_arb_pkg;

  localparam int unsigned DATA_W_DEFAULT = 64;
  localparam int unsigned KEEP_W_DEFAULT = DATA_W_DEFAULT / 8;
  localparam int unsigned STAT_W         = 32;
  localparam int unsigned IDX_W          = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/eth_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i (modulo NUM_IN)
// whose request bit is set.
module rr_pick
  import eth_arb_pkg::*;
#(
  parameter int unsigned NUM_IN = 4
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o
);

  // Walk offsets 1..NUM_IN from the last winner; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned off = 1; off <= NUM_IN; off++) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!found_o && req_i[i] && (i == (32'(last_i) + off) % NUM_IN)) begin
          idx_o   = IDX_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_IN Ethernet streams into one.
// Optional per-requester packet counters are enabled by defining ETH_ARB_STATS_EN.
module eth_stream_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] stream_in_DATA,
  input  logic [NUM_IN*KEEP_W-1:0] stream_in_KEEP,
  input  logic [NUM_IN-1:0]        stream_in_LAST,
  input  logic [NUM_IN-1:0]        stream_in_VALID,
  output logic [NUM_IN-1:0]        stream_in_READY,
  output logic [DATA_W-1:0]        stream_out_DATA,
  output logic [KEEP_W-1:0]        stream_out_KEEP,
  output logic                     stream_out_LAST,
  output logic                     stream_out_VALID,
  input  logic                     stream_out_READY,
  output logic [2:0]               grant_idx,
  output logic                     busy,
  output logic [NUM_IN*32-1:0]     stat_pkt_count
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             hs_last;

  rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req_i   (stream_in_VALID),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Output mux: forward the granted slice while BUSY, everything quiet in IDLE.
  always_comb begin
    stream_out_DATA  = '0;
    stream_out_KEEP  = '0;
    stream_out_LAST  = 1'b0;
    stream_out_VALID = 1'b0;
    stream_in_READY  = '0;
    if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (grant_q == IDX_W'(i)) begin
          stream_out_DATA    = stream_in_DATA[i*DATA_W +: DATA_W];
          stream_out_KEEP    = stream_in_KEEP[i*KEEP_W +: KEEP_W];
          stream_out_LAST    = stream_in_LAST[i];
          stream_out_VALID   = stream_in_VALID[i];
          stream_in_READY[i] = stream_out_READY;
        end
      end
    end
  end

  assign hs_last = (state_q == BUSY) && stream_out_VALID && stream_out_READY && stream_out_LAST;

  // Next-state: grab a winner from IDLE, release on the LAST handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs_last) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; last_q resets to NUM_IN-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_q;

`ifdef ETH_ARB_STATS_EN
  logic [NUM_IN-1:0][STAT_W-1:0] cnt_q, cnt_d;

  // Count completed packets per requester; wraps naturally at 2^STAT_W.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (hs_last && (grant_q == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_pkt_count = cnt_q;
`else
  assign stat_pkt_count = '0;
`endif

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Scoreboard bench for eth_stream_arbiter (default parameters). Exercises the
// stats counters when compiled with ETH_ARB_STATS_EN.
module tb_eth_stream_arbiter;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [63:0]              in_data [NUM_IN];
  logic [7:0]               in_keep [NUM_IN];
  logic [NUM_IN-1:0]        in_last = '0;
  logic [NUM_IN-1:0]        in_valid = '0;
  logic                     out_ready = 1'b1;
  logic [NUM_IN*DATA_W-1:0] bus_data;
  logic [NUM_IN*KEEP_W-1:0] bus_keep;
  logic [NUM_IN-1:0]        s_in_ready;
  logic [DATA_W-1:0]        s_out_data;
  logic [KEEP_W-1:0]        s_out_keep;
  logic                     s_out_last, s_out_valid, s_busy;
  logic [2:0]               s_grant;
  logic [NUM_IN*32-1:0]     s_stat;

  beat_t       txq  [NUM_IN][$];
  beat_t       expq [NUM_IN][$];
  int unsigned exp_grant_q[$];
  int unsigned grant_log[$];
  logic [31:0] pkt_cnt [NUM_IN];

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          m_busy, m_start;
  int unsigned m_last, m_grant;
  int unsigned gap_cnt [NUM_IN];
  int unsigned rand_gap_pct = 0;
  int unsigned or_stall_pct = 0;
  int unsigned or_low_cnt = 0;

  eth_stream_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_in_DATA   (bus_data),
    .stream_in_KEEP   (bus_keep),
    .stream_in_LAST   (in_last),
    .stream_in_VALID  (in_valid),
    .stream_in_READY  (s_in_ready),
    .stream_out_DATA  (s_out_data),
    .stream_out_KEEP  (s_out_keep),
    .stream_out_LAST  (s_out_last),
    .stream_out_VALID (s_out_valid),
    .stream_out_READY (out_ready),
    .grant_idx        (s_grant),
    .busy             (s_busy),
    .stat_pkt_count   (s_stat)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus_data = '0;
    bus_keep = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      bus_data[i*DATA_W +: DATA_W] = in_data[i];
      bus_keep[i*KEEP_W +: KEEP_W] = in_keep[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int unsigned rr_winner(input int unsigned last, input logic [NUM_IN-1:0] v);
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      if (v[(last + k) % NUM_IN]) return (last + k) % NUM_IN;
    end
    return 0;
  endfunction

  function automatic logic [31:0] stat_of(input int i);
    return s_stat[i*32 +: 32];
  endfunction

  task automatic reset_model();
    m_busy  = 1'b0;
    m_start = 1'b0;
    m_last  = NUM_IN - 1;
    m_grant = 0;
    exp_grant_q.delete();
    grant_log.delete();
    for (int i = 0; i < NUM_IN; i++) pkt_cnt[i] = '0;
  endtask

  // Driver: retire accepted beats, then present the next one (optionally gapped).
  initial begin
    logic [NUM_IN-1:0] took;
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i] = '0;
      in_keep[i] = '0;
      gap_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      took = in_valid & s_in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (took[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
          in_valid[i] = 1'b0;
        end else if (txq[i].size() > 0 && $urandom_range(99) >= rand_gap_pct) begin
          in_valid[i] = 1'b1;
          in_data[i]  = txq[i][0].d;
          in_keep[i]  = txq[i][0].k;
          in_last[i]  = txq[i][0].l;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      if (or_low_cnt > 0) begin
        or_low_cnt--;
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom_range(99) >= or_stall_pct);
      end
    end
  end

  // Monitor: compares DUT outputs against the transaction-level model.
  always @(negedge clk) begin
    beat_t b;
    int unsigned g;
    if (mon_en) begin
      if (!m_busy) begin
        chk("idle_busy", 64'(s_busy), 64'(0));
        chk("idle_out_valid", 64'(s_out_valid), 64'(0));
        chk("idle_ready", 64'(s_in_ready), 64'(0));
        chk("idle_out_bus", {s_out_data[54:0], s_out_keep, s_out_last}, 64'(0));
        if (|in_valid) begin
          exp_grant_q.push_back(rr_winner(m_last, in_valid));
          m_busy  = 1'b1;
          m_start = 1'b1;
        end
      end else begin
        if (m_start) begin
          g = exp_grant_q.pop_front();
          chk("grant", 64'(s_grant), 64'(g));
          m_grant = g;
          grant_log.push_back(g);
          m_start = 1'b0;
        end
        chk("busy", 64'(s_busy), 64'(1));
        chk("grant_hold", 64'(s_grant), 64'(m_grant));
        chk("ready_vec", 64'(s_in_ready), out_ready ? (64'(1) << m_grant) : 64'(0));
        chk("out_valid", 64'(s_out_valid), 64'(in_valid[m_grant]));
        if (in_valid[m_grant]) begin
          if (expq[m_grant].size() == 0) begin
            chk("unexpected_beat", 64'(expq[m_grant].size()), 64'(1));
          end else begin
            b = expq[m_grant][0];
            chk("out_data", s_out_data, b.d);
            chk("out_keep", 64'(s_out_keep), 64'(b.k));
            chk("out_last", 64'(s_out_last), 64'(b.l));
            if (out_ready) begin
              void'(expq[m_grant].pop_front());
              if (b.l) begin
                m_last = m_grant;
                m_busy = 1'b0;
                pkt_cnt[m_grant] = pkt_cnt[m_grant] + 32'd1;
              end
            end
          end
        end
      end
    end
  end

  task automatic push_beat(input int i, input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    txq[i].push_back(b);
    expq[i].push_back(b);
  endtask

  task automatic queue_pkt(input int i, input int len);
    for (int n = 0; n < len; n++) begin
      push_beat(i, {$urandom, $urandom}, 8'($urandom_range(1, 255)), n == len - 1);
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NUM_IN; i++) begin
      txq[i].delete();
      expq[i].delete();
      gap_cnt[i] = 0;
    end
    in_valid   = '0;
    or_low_cnt = 0;
  endtask

  // One-or-more-cycle reset; the cycle after the reset edge is checked directly.
  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    flush_all();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(s_busy), 64'(0));
    chk("rst_grant", 64'(s_grant), 64'(0));
    chk("rst_out_valid", 64'(s_out_valid), 64'(0));
    chk("rst_ready", 64'(s_in_ready), 64'(0));
    chk("rst_stats", 64'(|s_stat), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    reset_model();
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name, input int bound);
    int pending;
    for (int c = 0; c < bound; c++) begin
      pending = int'(m_busy);
      for (int i = 0; i < NUM_IN; i++) pending += expq[i].size();
      if (pending == 0) break;
      @(posedge clk); #2;
    end
    pending = int'(m_busy);
    for (int i = 0; i < NUM_IN; i++) pending += expq[i].size();
    chk(name, 64'(pending), 64'(0));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string name, input int unsigned exp[$]);
    chk({name, "_len"}, 64'(grant_log.size()), 64'(exp.size()));
    for (int n = 0; n < exp.size() && n < grant_log.size(); n++) begin
      chk(name, 64'(grant_log[n]), 64'(exp[n]));
    end
  endtask

  task automatic check_stats(input string name);
    for (int i = 0; i < NUM_IN; i++) begin
`ifdef ETH_ARB_STATS_EN
      chk(name, 64'(stat_of(i)), 64'(pkt_cnt[i]));
`else
      chk(name, 64'(stat_of(i)), 64'(0));
`endif
    end
  endtask

  initial begin
    do_reset(3);

    // Single 3-beat packet on input 2.
    push_beat(2, 64'h11, 8'hFF, 1'b0);
    push_beat(2, 64'h22, 8'hFF, 1'b0);
    push_beat(2, 64'h33, 8'h0F, 1'b1);
    drain("drain_in2", 50);
    check_log("order_in2", '{2});

    // All inputs offering 1-beat packets back to back.
    do_reset(1);
    queue_pkt(0, 1); queue_pkt(1, 1); queue_pkt(2, 1); queue_pkt(3, 1); queue_pkt(0, 1);
    drain("drain_all4", 60);
    check_log("order_all4", '{0, 1, 2, 3, 0});

    // Downstream stall of 5 cycles mid-packet on input 1.
    do_reset(1);
    queue_pkt(1, 3);
    for (int c = 0; c < 50 && expq[1].size() != 2; c++) begin @(posedge clk); #2; end
    chk("wait_in1_mid", 64'(expq[1].size()), 64'(2));
    or_low_cnt = 5;
    drain("drain_stall", 60);
    check_log("order_stall", '{1});

    // Granted input 0 pauses mid-packet while input 3 waits.
    do_reset(1);
    queue_pkt(0, 4);
    queue_pkt(3, 2);
    for (int c = 0; c < 50 && expq[0].size() != 2; c++) begin @(posedge clk); #2; end
    chk("wait_in0_mid", 64'(expq[0].size()), 64'(2));
    gap_cnt[0] = 3;
    drain("drain_gap", 60);
    check_log("order_gap", '{0, 3});

    // Reset on the second beat of a 4-beat packet, then requester 0 wins first.
    do_reset(1);
    queue_pkt(2, 4);
    for (int c = 0; c < 50 && expq[2].size() != 3; c++) begin @(posedge clk); #2; end
    chk("wait_in2_mid", 64'(expq[2].size()), 64'(3));
    do_reset(1);
    queue_pkt(2, 1);
    queue_pkt(0, 2);
    drain("drain_after_rst", 60);
    check_log("order_after_rst", '{0, 2});

    // Five packets from input 3, counter check, then wrap from all-ones.
    do_reset(1);
    for (int n = 0; n < 5; n++) queue_pkt(3, 1 + n % 3);
    drain("drain_stats", 200);
    check_stats("stats_in3");
`ifdef ETH_ARB_STATS_EN
    chk("stats_in3_five", 64'(stat_of(3)), 64'(5));
    force dut.cnt_q = {32'hFFFF_FFFF, {3{32'h0}}};
    @(posedge clk); #2;
    release dut.cnt_q;
    pkt_cnt[3] = 32'hFFFF_FFFF;
    queue_pkt(3, 2);
    drain("drain_wrap", 60);
    chk("stats_wrap", 64'(stat_of(3)), 64'(0));
    check_stats("stats_wrap_all");
`endif

    // Randomized traffic with input gaps and downstream stalls.
    do_reset(1);
    rand_gap_pct = 25;
    or_stall_pct = 30;
    for (int n = 0; n < 40; n++) queue_pkt($urandom_range(NUM_IN - 1), $urandom_range(1, 4));
    drain("drain_random", 5000);
    check_stats("stats_random");
    rand_gap_pct = 0;
    or_stall_pct = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
